// File: rtl/axi4l_pkg.sv
// Shared AXI4-Lite types: response codes and the slave FSM state encodings.
package axi4l_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef enum logic {
    WR_COLLECT = 1'b0,
    WR_RESP    = 1'b1
  } wr_state_t;

  typedef enum logic {
    RD_ADDR = 1'b0,
    RD_DATA = 1'b1
  } rd_state_t;

endpackage

// File: rtl/axi4l_regfile_core.sv
// Register storage with a byte-strobed write port and a registered read port.
// Out-of-range indices write nothing and read back as zero.
module axi4l_regfile_core #(
  parameter int DATA_SIZE = 32,
  parameter int IDX_W     = 8,
  parameter int NREGS     = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   we,
  input  logic [IDX_W-1:0]       widx,
  input  logic [DATA_SIZE-1:0]   wdata,
  input  logic [DATA_SIZE/8-1:0] wstrb,
  output logic                   widx_ok,
  input  logic                   re,
  input  logic [IDX_W-1:0]       ridx,
  output logic                   ridx_ok,
  output logic [DATA_SIZE-1:0]   rdata
);

  localparam int STRB_W = DATA_SIZE / 8;
  localparam int MEM_AW = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam logic [IDX_W:0] NREGS_V = NREGS[IDX_W:0];

  logic [DATA_SIZE-1:0] mem_r [NREGS];
  logic [DATA_SIZE-1:0] rdata_r;

  function automatic logic idx_in_range(input logic [IDX_W-1:0] idx);
    return ({1'b0, idx} < NREGS_V);
  endfunction

  assign widx_ok = idx_in_range(widx);
  assign ridx_ok = idx_in_range(ridx);
  assign rdata   = rdata_r;

  // Storage array: cleared on reset, byte lanes updated under strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        mem_r[i] <= '0;
      end
    end else if (we && widx_ok) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wstrb[b]) begin
          mem_r[widx[MEM_AW-1:0]][b*8 +: 8] <= wdata[b*8 +: 8];
        end
      end
    end
  end

  // Read register samples the pre-write array contents on a colliding edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_r <= '0;
    end else if (re) begin
      rdata_r <= ridx_ok ? mem_r[ridx[MEM_AW-1:0]] : '0;
    end
  end

endmodule

// File: rtl/axi4l_regfile_slave.sv
// AXI4-Lite slave exposing a byte-strobed register file; independent write
// and read channel FSMs, one outstanding transaction per channel.
module axi4l_regfile_slave
  import axi4l_pkg::*;
#(
  parameter int DATA_SIZE = 32,
  parameter int ADDR_SIZE = 10,
  parameter int NREGS     = 16
) (
  input  logic                   ACLK,
  input  logic                   ARESET,
  input  logic [ADDR_SIZE-1:0]   awaddr,
  input  logic                   awvalid,
  output logic                   awready,
  input  logic [DATA_SIZE-1:0]   wdata,
  input  logic [DATA_SIZE/8-1:0] wstrb,
  input  logic                   wvalid,
  output logic                   wready,
  output logic [1:0]             bresp,
  output logic                   bvalid,
  input  logic                   bready,
  input  logic [ADDR_SIZE-1:0]   araddr,
  input  logic                   arvalid,
  output logic                   arready,
  output logic [DATA_SIZE-1:0]   rdata,
  output logic [1:0]             rresp,
  output logic                   rvalid,
  input  logic                   rready
);

  localparam int STRB_W = DATA_SIZE / 8;
  localparam int LSB    = $clog2(STRB_W);
  localparam int IDX_W  = ADDR_SIZE - LSB;

  wr_state_t            wr_state_r;
  rd_state_t            rd_state_r;
  logic                 aw_held_r, w_held_r;
  logic [IDX_W-1:0]     awidx_r;
  logic [DATA_SIZE-1:0] wdata_r;
  logic [STRB_W-1:0]    wstrb_r;
  logic                 awready_r, wready_r, arready_r;
  logic                 bvalid_r, rvalid_r;
  resp_t                bresp_r, rresp_r;

  logic                 aw_hit_s, w_hit_s, ar_hit_s, commit_s;
  logic [IDX_W-1:0]     widx_s;
  logic [DATA_SIZE-1:0] wdata_s;
  logic [STRB_W-1:0]    wstrb_s;
  logic                 widx_ok_s, ridx_ok_s;
  logic                 unused_s;

  assign unused_s = ^{awaddr[LSB-1:0], araddr[LSB-1:0]};

  // A commit may use a freshly presented AW/W beat or the latched one.
  always_comb begin
    aw_hit_s = awvalid & awready_r;
    w_hit_s  = wvalid & wready_r;
    ar_hit_s = arvalid & arready_r;
    widx_s   = aw_held_r ? awidx_r : awaddr[ADDR_SIZE-1:LSB];
    wdata_s  = w_held_r ? wdata_r : wdata;
    wstrb_s  = w_held_r ? wstrb_r : wstrb;
    commit_s = (aw_held_r | aw_hit_s) & (w_held_r | w_hit_s);
  end

  axi4l_regfile_core #(
    .DATA_SIZE (DATA_SIZE),
    .IDX_W     (IDX_W),
    .NREGS     (NREGS)
  ) u_core (
    .clk     (ACLK),
    .rst     (ARESET),
    .we      (commit_s),
    .widx    (widx_s),
    .wdata   (wdata_s),
    .wstrb   (wstrb_s),
    .widx_ok (widx_ok_s),
    .re      (ar_hit_s),
    .ridx    (araddr[ADDR_SIZE-1:LSB]),
    .ridx_ok (ridx_ok_s),
    .rdata   (rdata)
  );

  // Write channel FSM: collect AW and W in any order, then hold B until taken.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      wr_state_r <= WR_COLLECT;
      aw_held_r  <= 1'b0;
      w_held_r   <= 1'b0;
      awidx_r    <= '0;
      wdata_r    <= '0;
      wstrb_r    <= '0;
      awready_r  <= 1'b0;
      wready_r   <= 1'b0;
      bvalid_r   <= 1'b0;
      bresp_r    <= OKAY;
    end else begin
      case (wr_state_r)
        WR_COLLECT: begin
          if (aw_hit_s) begin
            awidx_r <= awaddr[ADDR_SIZE-1:LSB];
          end
          if (w_hit_s) begin
            wdata_r <= wdata;
            wstrb_r <= wstrb;
          end
          if (commit_s) begin
            aw_held_r  <= 1'b0;
            w_held_r   <= 1'b0;
            awready_r  <= 1'b0;
            wready_r   <= 1'b0;
            bvalid_r   <= 1'b1;
            bresp_r    <= widx_ok_s ? OKAY : SLVERR;
            wr_state_r <= WR_RESP;
          end else begin
            aw_held_r <= aw_held_r | aw_hit_s;
            w_held_r  <= w_held_r | w_hit_s;
            awready_r <= ~(aw_held_r | aw_hit_s);
            wready_r  <= ~(w_held_r | w_hit_s);
          end
        end
        WR_RESP: begin
          if (bready) begin
            bvalid_r   <= 1'b0;
            awready_r  <= 1'b1;
            wready_r   <= 1'b1;
            wr_state_r <= WR_COLLECT;
          end
        end
        default: begin
          wr_state_r <= WR_COLLECT;
          aw_held_r  <= 1'b0;
          w_held_r   <= 1'b0;
          awready_r  <= 1'b0;
          wready_r   <= 1'b0;
          bvalid_r   <= 1'b0;
        end
      endcase
    end
  end

  // Read channel FSM: accept AR, then hold R until taken.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      rd_state_r <= RD_ADDR;
      arready_r  <= 1'b0;
      rvalid_r   <= 1'b0;
      rresp_r    <= OKAY;
    end else begin
      case (rd_state_r)
        RD_ADDR: begin
          if (ar_hit_s) begin
            arready_r  <= 1'b0;
            rvalid_r   <= 1'b1;
            rresp_r    <= ridx_ok_s ? OKAY : SLVERR;
            rd_state_r <= RD_DATA;
          end else begin
            arready_r <= 1'b1;
          end
        end
        RD_DATA: begin
          if (rready) begin
            rvalid_r   <= 1'b0;
            arready_r  <= 1'b1;
            rd_state_r <= RD_ADDR;
          end
        end
        default: begin
          rd_state_r <= RD_ADDR;
          arready_r  <= 1'b0;
          rvalid_r   <= 1'b0;
        end
      endcase
    end
  end

  assign awready = awready_r;
  assign wready  = wready_r;
  assign arready = arready_r;
  assign bvalid  = bvalid_r;
  assign bresp   = bresp_r;
  assign rvalid  = rvalid_r;
  assign rresp   = rresp_r;

endmodule

// File: tb/tb_axi4l_regfile_slave.sv
// Directed bench for axi4l_regfile_slave: drives and samples on the falling edge.
module tb_axi4l_regfile_slave;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [9:0]  awaddr, araddr;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;

  int compared = 0;
  int mismatched = 0;

  always #5 ACLK = ~ACLK;

  axi4l_regfile_slave #(.DATA_SIZE(32), .ADDR_SIZE(10), .NREGS(16)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Full write with AW/W together; assumes both readies are up on entry.
  task automatic wr(input string tag, input logic [9:0] a, input logic [31:0] d,
                    input logic [3:0] s, input logic [1:0] er);
    awaddr = a; awvalid = 1'b1; wdata = d; wstrb = s; wvalid = 1'b1;
    @(negedge ACLK);
    chk({tag, "_bvalid"}, bvalid, 1'b1);
    chk({tag, "_bresp"}, bresp, er);
    awvalid = 1'b0; wvalid = 1'b0;
    @(negedge ACLK);
    chk({tag, "_bdone"}, bvalid, 1'b0);
  endtask

  task automatic rd(input string tag, input logic [9:0] a, input logic [31:0] ed,
                    input logic [1:0] er);
    araddr = a; arvalid = 1'b1;
    @(negedge ACLK);
    chk({tag, "_rvalid"}, rvalid, 1'b1);
    chk({tag, "_rdata"}, rdata, ed);
    chk({tag, "_rresp"}, rresp, er);
    arvalid = 1'b0;
    @(negedge ACLK);
    chk({tag, "_rdone"}, rvalid, 1'b0);
  endtask

  initial begin
    ARESET = 1'b1;
    awaddr = 10'h000; awvalid = 1'b0; wdata = 32'h0; wstrb = 4'h0; wvalid = 1'b0;
    bready = 1'b1; araddr = 10'h000; arvalid = 1'b0; rready = 1'b1;

    // Reset state
    #3;
    chk("rst_awready", awready, 1'b0);
    chk("rst_wready", wready, 1'b0);
    chk("rst_arready", arready, 1'b0);
    chk("rst_bvalid", bvalid, 1'b0);
    chk("rst_rvalid", rvalid, 1'b0);
    chk("rst_rdata", rdata, 32'h0);
    @(negedge ACLK);
    ARESET = 1'b0;
    @(negedge ACLK);
    chk("post_awready", awready, 1'b1);
    chk("post_wready", wready, 1'b1);
    chk("post_arready", arready, 1'b1);

    // 1: basic write and readback
    wr("t1_wr", 10'h004, 32'hDEADBEEF, 4'hF, 2'b00);
    rd("t1_rd", 10'h004, 32'hDEADBEEF, 2'b00);

    // 2: W arrives three cycles before AW, single byte lane
    wr("t2_pre", 10'h008, 32'h11223344, 4'hF, 2'b00);
    wdata = 32'h000000AA; wstrb = 4'h1; wvalid = 1'b1;
    @(negedge ACLK);
    wvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("t2_wready_held", wready, 1'b0);
      chk("t2_awready_open", awready, 1'b1);
      chk("t2_no_bvalid", bvalid, 1'b0);
      if (i < 2) @(negedge ACLK);
    end
    awaddr = 10'h008; awvalid = 1'b1;
    @(negedge ACLK);
    chk("t2_bvalid", bvalid, 1'b1);
    chk("t2_bresp", bresp, 2'b00);
    awvalid = 1'b0;
    @(negedge ACLK);
    chk("t2_bdone", bvalid, 1'b0);
    rd("t2_rd", 10'h008, 32'h112233AA, 2'b00);

    // 3: out-of-range write and read
    wr("t3_wr", 10'h040, 32'hFFFFFFFF, 4'hF, 2'b10);
    rd("t3_rd0", 10'h000, 32'h0, 2'b00);
    rd("t3_rd4", 10'h004, 32'hDEADBEEF, 2'b00);
    rd("t3_rd3c", 10'h03C, 32'h0, 2'b00);
    rd("t3_rdoor", 10'h3FC, 32'h0, 2'b10);

    // 4: B backpressure, second write waits
    bready = 1'b0;
    wr_nowait(10'h010, 32'h0BADF00D);
    awaddr = 10'h014; wdata = 32'h12345678; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("t4_bvalid_hold", bvalid, 1'b1);
      chk("t4_bresp_hold", bresp, 2'b00);
      chk("t4_awready_low", awready, 1'b0);
      chk("t4_wready_low", wready, 1'b0);
      @(negedge ACLK);
    end
    bready = 1'b1;
    @(negedge ACLK);
    chk("t4_b_cleared", bvalid, 1'b0);
    chk("t4_awready_back", awready, 1'b1);
    @(negedge ACLK);
    chk("t4_second_bvalid", bvalid, 1'b1);
    chk("t4_second_bresp", bresp, 2'b00);
    awvalid = 1'b0; wvalid = 1'b0;
    @(negedge ACLK);
    rd("t4_rd10", 10'h010, 32'h0BADF00D, 2'b00);
    rd("t4_rd14", 10'h014, 32'h12345678, 2'b00);

    // 5: read/write collision on the same register
    wr("t5_pre", 10'h00C, 32'h99999999, 4'hF, 2'b00);
    awaddr = 10'h00C; wdata = 32'h00000055; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1; araddr = 10'h00C; arvalid = 1'b1;
    @(negedge ACLK);
    chk("t5_bvalid", bvalid, 1'b1);
    chk("t5_rvalid", rvalid, 1'b1);
    chk("t5_old_data", rdata, 32'h99999999);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    @(negedge ACLK);
    rd("t5_new", 10'h00C, 32'h00000055, 2'b00);

    // 6: reset during pending R and a held W
    rready = 1'b0;
    araddr = 10'h004; arvalid = 1'b1;
    wdata = 32'h0000CAFE; wstrb = 4'hF; wvalid = 1'b1;
    @(negedge ACLK);
    chk("t6_rvalid_pend", rvalid, 1'b1);
    chk("t6_w_held", wready, 1'b0);
    arvalid = 1'b0; wvalid = 1'b0;
    #2 ARESET = 1'b1;
    #1;
    chk("t6_rvalid_async", rvalid, 1'b0);
    chk("t6_rdata_async", rdata, 32'h0);
    chk("t6_arready_async", arready, 1'b0);
    chk("t6_wready_async", wready, 1'b0);
    @(negedge ACLK);
    ARESET = 1'b0; rready = 1'b1;
    @(negedge ACLK);
    chk("t6_wready_back", wready, 1'b1);
    rd("t6_rd4", 10'h004, 32'h0, 2'b00);
    rd("t6_rdc", 10'h00C, 32'h0, 2'b00);
    rd("t6_rd14", 10'h014, 32'h0, 2'b00);
    // The discarded W must not pair with a fresh AW.
    wr("t6_wr", 10'h018, 32'hA5A5A5A5, 4'h3, 2'b00);
    rd("t6_rd18", 10'h018, 32'h0000A5A5, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // Issue a write and leave B pending (bready is low).
  task automatic wr_nowait(input logic [9:0] a, input logic [31:0] d);
    awaddr = a; awvalid = 1'b1; wdata = d; wstrb = 4'hF; wvalid = 1'b1;
    @(negedge ACLK);
    awvalid = 1'b0; wvalid = 1'b0;
  endtask

endmodule
